cache_wb_sched: RTL and testbench
=================================

// Module: cache_wb_sched
// PURPOSE
//  Writeback scheduler for the cache line-state array (per-set V/D/PTC FSMs).
//  Serves two requesters: whole-cache flush and single-set eviction from the miss handler.
//  For each valid+dirty line: memory writeback handshake, then one-cycle wb pulse to that set's FSM.
//  Sits between the miss handler, the line-state FSMs and the memory-side bus interface.
// PARAMETERS
//  NUM_SETS  8   number of line-state FSMs scanned (power of 2, >=2)
//  SET_W     3   index width, = log2(NUM_SETS)
// PORTS
//  clk          in   1         clock, rising edge
//  rst          in   1         asynchronous reset, active-high
//  flush_req    in   1         1-cycle pulse: flush all V&D lines
//  flush_done   out  1         1-cycle pulse: flush complete
//  evict_req    in   1         eviction request (valid)
//  evict_set    in   SET_W     set to evict, sampled on accept
//  evict_ready  out  1         high only in IDLE; accept = evict_req & evict_ready
//  evict_done   out  1         1-cycle pulse: eviction complete
//  v_vec        in   NUM_SETS  V bit of each set
//  d_vec        in   NUM_SETS  D bit of each set
//  line_sel     out  SET_W     set currently addressed (scan index)
//  wb_pulse     out  1         1-cycle wb strobe to FSM at line_sel
//  mem_req      out  1         writeback request, held until ack
//  mem_set      out  SET_W     set being written back, stable while mem_req
//  mem_ack      in   1         writeback accepted by memory
//  busy         out  1         high in any state other than IDLE
//  wb_count     out  16        writebacks completed (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async): state=IDLE, idx=0, mode=0, flush_pend=0; all outputs 0 except evict_ready=1.
//  States: IDLE, SCAN, WB_REQ, WB_CLR, DONE. Registered state; outputs decoded from state.
//  IDLE: evict accept -> idx<=evict_set, mode=EVICT, go SCAN.
//        else flush_req|flush_pend -> idx<=0, mode=FLUSH, clear flush_pend, go SCAN.
//        Simultaneous evict and flush: evict wins, flush latched into flush_pend.
//  SCAN (1 cycle per set): line_sel=idx. If v_vec[idx]&d_vec[idx] -> WB_REQ.
//        Else EVICT -> IDLE + evict_done; FLUSH & idx==NUM_SETS-1 -> DONE; FLUSH else idx+1, stay.
//  WB_REQ: mem_req=1, mem_set=idx, until mem_ack sampled high (may be same cycle as first req) -> WB_CLR.
//  WB_CLR: wb_pulse=1, line_sel=idx for exactly 1 cycle; wb_count+1.
//        EVICT -> IDLE + evict_done; FLUSH & last idx -> DONE; FLUSH else idx+1 -> SCAN.
//  DONE: flush_done=1 for 1 cycle -> IDLE.
//  evict_done asserted in the cycle the IDLE transition is made (registered pulse, 1 cycle).
//  flush_req while busy: set flush_pend (no loss, no double count); evict_req while busy: not accepted.
//  mem_ack outside WB_REQ: ignored. idx wraps never (bounded by last-set check).
//  Clean full flush latency: NUM_SETS+2 cycles flush_req->flush_done; each dirty line adds 2 + ack wait.
//  v_vec/d_vec sampled only in SCAN; changes mid-writeback do not abort it.
//  rst mid-operation: immediate return to IDLE, mem_req/wb_pulse drop asynchronously, pends cleared.
// CONFIGURATION
//  CACHE_WB_SCHED_PERF_EN defined: wb_count is 16-bit counter, reset 0, +1 per WB_CLR, wraps 0xFFFF->0.
//  Not defined: counter not built, wb_count tied to 16'h0000.
// TESTING
//  Reset mid-WB_REQ -> mem_req=0 same cycle, busy=0, evict_ready=1, wb_count=0.
//  Flush, v=8'hFF d=8'h00 -> no mem_req, flush_done exactly 10 cycles after flush_req.
//  Flush, v=8'hFF d=8'h24, mem_ack 3 cycles late -> mem_set=2 then 5, wb_pulse with line_sel=2,5, count=2.
//  Evict set 6 with v=d=1, mem_ack same cycle -> mem_req 1 cycle, wb_pulse line_sel=6, evict_done.
//  Evict set 1 clean plus flush_req same cycle -> evict_done first, then full flush, one flush_done.
//  PERF_EN, preload count 0xFFFF via 65535 writebacks (or force) -> next writeback wraps to 0x0000.

Source files
------------

// File: rtl/cache_wb_sched.sv
// cache_wb_sched: writeback scheduler for the per-set line-state FSMs.
// It serves two requesters: a whole-cache flush and a single-set eviction.
// For every valid and dirty line it completes a memory writeback handshake.
// After the handshake it sends a one-cycle wb strobe to that set's FSM.
// Optional feature macro: CACHE_WB_SCHED_PERF_EN builds the wb_count counter.
// Without the macro, wb_count is tied to zero.
//
// state    | meaning
// IDLE     | waiting; only state that accepts an eviction
// SCAN     | examine v/d of set idx (one cycle per set)
// WB_REQ   | mem_req held for set idx until mem_ack
// WB_CLR   | one-cycle wb_pulse to set idx
// DONE     | flush finished; flush_done follows on the return to IDLE
module cache_wb_sched #(
    parameter int NUM_SETS = 8,
    parameter int SET_W    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_req,
    output logic                flush_done,
    input  logic                evict_req,
    input  logic [SET_W-1:0]    evict_set,
    output logic                evict_ready,
    output logic                evict_done,
    input  logic [NUM_SETS-1:0] v_vec,
    input  logic [NUM_SETS-1:0] d_vec,
    output logic [SET_W-1:0]    line_sel,
    output logic                wb_pulse,
    output logic                mem_req,
    output logic [SET_W-1:0]    mem_set,
    input  logic                mem_ack,
    output logic                busy,
    output logic [15:0]         wb_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_WB_REQ,
        S_WB_CLR,
        S_DONE
    } state_t;

    localparam logic [SET_W-1:0] LAST_IDX = SET_W'(NUM_SETS - 1);

    state_t           state;
    logic [SET_W-1:0] idx;
    logic             mode_flush;
    logic             flush_pend;
    logic             evict_done_q;
    logic             flush_done_q;
    logic             line_dirty;
    logic             idx_last;

    assign line_dirty = v_vec[idx] & d_vec[idx];
    assign idx_last   = (idx == LAST_IDX);

    // Control FSM. Both done pulses are registered on the edge that returns to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            idx          <= '0;
            mode_flush   <= 1'b0;
            flush_pend   <= 1'b0;
            evict_done_q <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            evict_done_q <= 1'b0;
            flush_done_q <= 1'b0;
            // A flush request that arrives mid-operation is remembered and is never lost.
            if (flush_req && (state != S_IDLE)) begin
                flush_pend <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (evict_req) begin
                        idx        <= evict_set;
                        mode_flush <= 1'b0;
                        state      <= S_SCAN;
                        if (flush_req) begin
                            flush_pend <= 1'b1;
                        end
                    end else if (flush_req || flush_pend) begin
                        idx        <= '0;
                        mode_flush <= 1'b1;
                        flush_pend <= 1'b0;
                        state      <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (line_dirty) begin
                        state <= S_WB_REQ;
                    end else if (!mode_flush) begin
                        state        <= S_IDLE;
                        evict_done_q <= 1'b1;
                    end else if (idx_last) begin
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_WB_REQ: begin
                    if (mem_ack) begin
                        state <= S_WB_CLR;
                    end
                end
                S_WB_CLR: begin
                    if (!mode_flush) begin
                        state        <= S_IDLE;
                        evict_done_q <= 1'b1;
                    end else if (idx_last) begin
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_SCAN;
                    end
                end
                S_DONE: begin
                    state        <= S_IDLE;
                    flush_done_q <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // The handshake outputs decode directly from the state, so reset drops them at once.
    assign line_sel    = idx;
    assign mem_set     = idx;
    assign mem_req     = (state == S_WB_REQ);
    assign wb_pulse    = (state == S_WB_CLR);
    assign busy        = (state != S_IDLE);
    assign evict_ready = (state == S_IDLE);
    assign evict_done  = evict_done_q;
    assign flush_done  = flush_done_q;

`ifdef CACHE_WB_SCHED_PERF_EN
    logic [15:0] wb_count_q;

    // Completed writebacks; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_count_q <= 16'h0000;
        end else if (state == S_WB_CLR) begin
            wb_count_q <= wb_count_q + 16'h0001;
        end
    end

    assign wb_count = wb_count_q;
`else
    assign wb_count = 16'h0000;
`endif

endmodule

// File: tb/tb_cache_wb_sched.sv
// Self-checking bench for cache_wb_sched.
// It applies a vector table of flush/evict scenarios through a scoreboard.
// It then runs hand sequences for reset during a writeback and for a stray mem_ack.
module tb_cache_wb_sched;

    localparam int NUM_SETS = 8;
    localparam int SET_W    = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                flush_req;
    logic                flush_done;
    logic                evict_req;
    logic [SET_W-1:0]    evict_set;
    logic                evict_ready;
    logic                evict_done;
    logic [NUM_SETS-1:0] v_vec;
    logic [NUM_SETS-1:0] d_vec;
    logic [SET_W-1:0]    line_sel;
    logic                wb_pulse;
    logic                mem_req;
    logic [SET_W-1:0]    mem_set;
    logic                mem_ack;
    logic                busy;
    logic [15:0]         wb_count;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_count = 16'h0000;

    cache_wb_sched #(.NUM_SETS(NUM_SETS), .SET_W(SET_W)) dut (
        .clk(clk), .rst(rst),
        .flush_req(flush_req), .flush_done(flush_done),
        .evict_req(evict_req), .evict_set(evict_set),
        .evict_ready(evict_ready), .evict_done(evict_done),
        .v_vec(v_vec), .d_vec(d_vec),
        .line_sel(line_sel), .wb_pulse(wb_pulse),
        .mem_req(mem_req), .mem_set(mem_set), .mem_ack(mem_ack),
        .busy(busy), .wb_count(wb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string          name;
        logic           do_flush;
        logic           do_evict;
        logic [2:0]     eset;
        logic [7:0]     v;
        logic [7:0]     d;
        int             k;       // ack delay in cycles after mem_req appears
        int             exp_ev;  // cycles from request to evict_done
        int             exp_fl;  // cycles from request to flush_done
    } vec_t;

    vec_t vecs[9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t t);
        logic [2:0] exp_q[$];
        int cyc, ev_cyc, fl_cyc, ev_n, fl_n, mreq_n, wait_cnt, nwb, need_ev, need_fl, tail;
        logic [2:0] exp_set;
        if (t.do_evict && t.v[t.eset] && t.d[t.eset]) exp_q.push_back(t.eset);
        if (t.do_flush) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                if (t.v[i] && t.d[i]) exp_q.push_back(3'(i));
            end
        end
        nwb     = exp_q.size();
        need_ev = t.do_evict ? 1 : 0;
        need_fl = t.do_flush ? 1 : 0;
        v_vec     = t.v;
        d_vec     = t.d;
        flush_req = t.do_flush;
        evict_req = t.do_evict;
        evict_set = t.eset;
        cyc = 0; ev_cyc = -1; fl_cyc = -1; ev_n = 0; fl_n = 0;
        mreq_n = 0; wait_cnt = 0; tail = 0;
        while (cyc < 300) begin
            step();
            cyc++;
            flush_req = 1'b0;
            evict_req = 1'b0;
            if (mem_req) begin
                if (exp_q.size() == 0) begin
                    chk({t.name, " unexpected_mem_req"}, 32'(mem_set), 32'hFFFF_FFFF);
                end else begin
                    exp_set = exp_q[0];
                    chk({t.name, " mem_set"}, 32'(mem_set), 32'(exp_set));
                end
                mreq_n++;
                mem_ack = (wait_cnt == t.k);
                wait_cnt++;
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end
            if (wb_pulse) begin
                if (exp_q.size() == 0) begin
                    chk({t.name, " unexpected_wb_pulse"}, 32'(line_sel), 32'hFFFF_FFFF);
                end else begin
                    exp_set = exp_q.pop_front();
                    chk({t.name, " wb_line_sel"}, 32'(line_sel), 32'(exp_set));
                end
            end
            if (evict_done) begin
                ev_n++;
                if (ev_cyc < 0) ev_cyc = cyc;
            end
            if (flush_done) begin
                fl_n++;
                if (fl_cyc < 0) fl_cyc = cyc;
            end
            if (ev_n >= need_ev && fl_n >= need_fl) begin
                tail++;
                if (tail > 4) break;
            end
        end
        mem_ack = 1'b0;
        if (cyc >= 300) chk({t.name, " timeout"}, 32'(cyc), 32'd0);
        if (t.do_evict) chk({t.name, " evict_done_cycle"}, 32'(ev_cyc), 32'(t.exp_ev));
        if (t.do_flush) chk({t.name, " flush_done_cycle"}, 32'(fl_cyc), 32'(t.exp_fl));
        chk({t.name, " evict_done_count"}, 32'(ev_n), 32'(need_ev));
        chk({t.name, " flush_done_count"}, 32'(fl_n), 32'(need_fl));
        chk({t.name, " wb_left"}, 32'(exp_q.size()), 32'd0);
        chk({t.name, " mem_req_cycles"}, 32'(mreq_n), 32'(nwb * (t.k + 1)));
`ifdef CACHE_WB_SCHED_PERF_EN
        exp_count = exp_count + 16'(nwb);
`endif
        chk({t.name, " wb_count"}, 32'(wb_count), 32'(exp_count));
        chk({t.name, " busy_end"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        vecs[0] = '{"flush_clean",      1'b1, 1'b0, 3'd0, 8'hFF, 8'h00, 0, 0, 10};
        vecs[1] = '{"flush_2_5_late",   1'b1, 1'b0, 3'd0, 8'hFF, 8'h24, 3, 0, 20};
        vecs[2] = '{"evict6_dirty",     1'b0, 1'b1, 3'd6, 8'h40, 8'h40, 0, 4, 0};
        vecs[3] = '{"evict1_and_flush", 1'b1, 1'b1, 3'd1, 8'hFF, 8'h00, 0, 2, 12};
        vecs[4] = '{"flush_v_d_disj",   1'b1, 1'b0, 3'd0, 8'h0F, 8'hF0, 0, 0, 10};
        vecs[5] = '{"flush_0_7",        1'b1, 1'b0, 3'd0, 8'hFF, 8'h81, 1, 0, 16};
        vecs[6] = '{"evict7_dirty",     1'b0, 1'b1, 3'd7, 8'h80, 8'h80, 2, 6, 0};
        vecs[7] = '{"evict3_and_flush", 1'b1, 1'b1, 3'd3, 8'hFF, 8'h08, 0, 4, 16};
        vecs[8] = '{"evict0_invalid",   1'b0, 1'b1, 3'd0, 8'h00, 8'h01, 0, 2, 0};

        rst = 1'b1; flush_req = 1'b0; evict_req = 1'b0; evict_set = '0;
        v_vec = '0; d_vec = '0; mem_ack = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst busy",        32'(busy),        32'd0);
        chk("rst evict_ready", 32'(evict_ready), 32'd1);
        chk("rst mem_req",     32'(mem_req),     32'd0);
        chk("rst wb_pulse",    32'(wb_pulse),    32'd0);
        chk("rst dones",       32'({flush_done, evict_done}), 32'd0);
        chk("rst line_sel",    32'(line_sel),    32'd0);
        chk("rst wb_count",    32'(wb_count),    32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // A mem_ack held high outside WB_REQ must not change a clean flush.
        v_vec = 8'hFF; d_vec = 8'h00; mem_ack = 1'b1; flush_req = 1'b1;
        n = 0;
        for (int c = 1; c <= 14; c++) begin
            step();
            flush_req = 1'b0;
            if (mem_req || wb_pulse) chk("stray_ack mem_req", 32'(c), 32'd0);
            if (flush_done) begin
                n++;
                chk("stray_ack flush_cycle", 32'(c), 32'd10);
            end
        end
        chk("stray_ack flush_count", 32'(n), 32'd1);
        mem_ack = 1'b0;

`ifdef CACHE_WB_SCHED_PERF_EN
        force dut.wb_count_q = 16'hFFFF;
        #1;
        release dut.wb_count_q;
        exp_count = 16'hFFFF;
        run_vec('{"wrap_evict", 1'b0, 1'b1, 3'd4, 8'h10, 8'h10, 0, 4, 0});
`endif

        // Reset while WB_REQ is waiting, with a flush pending behind it.
        v_vec = 8'h01; d_vec = 8'h01; flush_req = 1'b1;
        n = 0;
        for (int c = 0; c < 10 && !mem_req; c++) begin
            step();
            flush_req = 1'b0;
            n++;
        end
        chk("rst_mid mem_req_seen", 32'(mem_req), 32'd1);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        rst = 1'b1;
        #1;
        exp_count = 16'h0000;
        chk("rst_mid mem_req",     32'(mem_req),     32'd0);
        chk("rst_mid busy",        32'(busy),        32'd0);
        chk("rst_mid evict_ready", 32'(evict_ready), 32'd1);
        chk("rst_mid wb_count",    32'(wb_count),    32'd0);
        step();
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (busy) n++;
        end
        chk("rst_mid pend_cleared", 32'(n), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
